// File: rtl/multiport_register_file_if.sv
// Bus bundle for the multiport register file: write ports, read ports and the
// issue-side scoreboard claim. The master drives requests; the slave is the file.
interface multiport_register_file_if #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 1
);
   localparam int AW = $clog2(NREGS);

   logic [NWR-1:0]       wen;
   logic [NWR*AW-1:0]    wsel;
   logic [NWR*WIDTH-1:0] wdat;
   logic [NRD*AW-1:0]    rsel;
   logic [NRD*WIDTH-1:0] rdat;
   logic [NRD-1:0]       rbusy;
   logic                 claim_en;
   logic [AW-1:0]        claim_sel;
   logic [NREGS-1:0]     busy_vec;

   modport master (
      output wen, wsel, wdat, rsel, claim_en, claim_sel,
      input  rdat, rbusy, busy_vec
   );

   modport slave (
      input  wen, wsel, wdat, rsel, claim_en, claim_sel,
      output rdat, rbusy, busy_vec
   );
endinterface

// File: rtl/multiport_register_file.sv
// Integer register file: NRD combinational reads, NWR synchronous writes, r0 hardwired
// to zero, optional write-to-read bypass, and a per-register busy scoreboard.
module multiport_register_file #(
   parameter int WIDTH  = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 1,
   parameter int BYPASS = 1
) (
   input  logic                      clk,
   input  logic                      n_rst,
   multiport_register_file_if.slave  bus
);
   localparam int AW = $clog2(NREGS);

   logic [NREGS-1:0][WIDTH-1:0] r_regs;
   logic [NREGS-1:0]            r_busy;

   logic [NREGS-1:0]            w_wr_hit;
   logic [NREGS-1:0][WIDTH-1:0] w_wr_data;
   logic [NREGS-1:0]            w_claim_hit;
   logic [NRD-1:0][WIDTH-1:0]   w_rdat;
   logic [NRD-1:0]              w_rbusy;
   logic [AW-1:0]               w_rsel;

   // Per-register write decode; ascending port scan lets the highest port win.
   // Index 0 is never decoded, so r0 is never written, claimed or cleared.
   always_comb begin
      w_wr_hit    = '0;
      w_wr_data   = '0;
      w_claim_hit = '0;
      for (int i = 1; i < NREGS; i++) begin
         w_claim_hit[i] = bus.claim_en && (bus.claim_sel == AW'(i));
         for (int k = 0; k < NWR; k++) begin
            if (bus.wen[k] && (bus.wsel[k*AW +: AW] == AW'(i))) begin
               w_wr_hit[i]  = 1'b1;
               w_wr_data[i] = bus.wdat[k*WIDTH +: WIDTH];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_regs <= '0;
         r_busy <= '0;
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (w_wr_hit[i])
               r_regs[i] <= w_wr_data[i];
            // A same-cycle claim belongs to a newer producer, so it beats the writeback.
            if (w_claim_hit[i])
               r_busy[i] <= 1'b1;
            else if (w_wr_hit[i])
               r_busy[i] <= 1'b0;
         end
      end
   end

   always_comb begin
      w_rdat  = '0;
      w_rbusy = '0;
      w_rsel  = '0;
      for (int j = 0; j < NRD; j++) begin
         w_rsel     = bus.rsel[j*AW +: AW];
         w_rdat[j]  = r_regs[w_rsel];
         w_rbusy[j] = r_busy[w_rsel];
         if ((BYPASS != 0) && w_wr_hit[w_rsel]) begin
            w_rdat[j] = w_wr_data[w_rsel];
            if (!w_claim_hit[w_rsel])
               w_rbusy[j] = 1'b0;
         end
         // Forwarded write data must not leak out while reset is held.
         if (!n_rst) begin
            w_rdat[j]  = '0;
            w_rbusy[j] = 1'b0;
         end
      end
   end

   assign bus.rdat     = w_rdat;
   assign bus.rbusy    = w_rbusy;
   assign bus.busy_vec = r_busy;
endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: A is NWR=2/BYPASS=1, B is NWR=1/BYPASS=0; expectations hand-computed.
module tb_multiport_register_file;
   logic clk;
   logic n_rst;
   int   tests;
   int   fails;
   logic [31:0] mdl [32];

   multiport_register_file_if #(.WIDTH(32), .NREGS(32), .NRD(2), .NWR(2)) ia ();
   multiport_register_file_if #(.WIDTH(32), .NREGS(32), .NRD(2), .NWR(1)) ib ();

   multiport_register_file #(.WIDTH(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_a (
      .clk(clk), .n_rst(n_rst), .bus(ia));
   multiport_register_file #(.WIDTH(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) u_b (
      .clk(clk), .n_rst(n_rst), .bus(ib));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected summary before 200000");
      $fatal(1, "watchdog");
   end

   task automatic idle;
      ia.wen = '0; ia.wsel = '0; ia.wdat = '0; ia.rsel = '0; ia.claim_en = 1'b0; ia.claim_sel = '0;
      ib.wen = '0; ib.wsel = '0; ib.wdat = '0; ib.rsel = '0; ib.claim_en = 1'b0; ib.claim_sel = '0;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      idle();
      n_rst = 1'b0;
      #3;
      for (int r = 0; r < 32; r++) begin
         ia.rsel = {5'(r), 5'(r)};
         ib.rsel = {5'(r), 5'(r)};
         #1;
         tests++;
         if (ia.rdat !== 64'd0 || ib.rdat !== 64'd0 || ia.rbusy !== 2'b00 || ib.rbusy !== 2'b00) begin
            fails++;
            $display("FAIL reset_read r%0d: a=%h b=%h busy a=%b b=%b, want all 0",
                     r, ia.rdat, ib.rdat, ia.rbusy, ib.rbusy);
         end
      end
      tests++;
      if (ia.busy_vec !== 32'd0 || ib.busy_vec !== 32'd0) begin
         fails++;
         $display("FAIL reset_busy: a=%h b=%h want 0", ia.busy_vec, ib.busy_vec);
      end
      // Write + matching read while in reset: forwarded data must still read 0
      ia.wen = 2'b01; ia.wsel[4:0] = 5'd5; ia.wdat[31:0] = 32'hCAFEF00D; ia.rsel[4:0] = 5'd5;
      #1;
      tests++;
      if (ia.rdat[31:0] !== 32'd0) begin
         fails++;
         $display("FAIL reset_bypass: got %h want 0", ia.rdat[31:0]);
      end
      idle();
      n_rst = 1'b1;
      next_cycle();
   endtask

   task automatic test_write_read;
      ia.wen = 2'b01; ia.wsel[4:0] = 5'd5; ia.wdat[31:0] = 32'hDEADBEEF;
      ib.wen = 1'b1;  ib.wsel      = 5'd5; ib.wdat      = 32'hDEADBEEF;
      next_cycle();
      idle();
      ia.rsel[4:0] = 5'd5; ib.rsel[4:0] = 5'd5;
      #1;
      tests++;
      if (ia.rdat[31:0] !== 32'hDEADBEEF || ib.rdat[31:0] !== 32'hDEADBEEF) begin
         fails++;
         $display("FAIL write_r5: a=%h b=%h want deadbeef", ia.rdat[31:0], ib.rdat[31:0]);
      end
      // r0 write with a same-cycle r0 read: no bypass onto r0 either
      ia.wen = 2'b01; ia.wsel[4:0] = 5'd0; ia.wdat[31:0] = 32'h1234; ia.rsel = '0;
      ib.wen = 1'b1;  ib.wsel      = 5'd0; ib.wdat      = 32'h1234; ib.rsel = '0;
      #1;
      tests++;
      if (ia.rdat[31:0] !== 32'd0) begin
         fails++;
         $display("FAIL r0_bypass: got %h want 0", ia.rdat[31:0]);
      end
      next_cycle();
      idle();
      #1;
      tests++;
      if (ia.rdat !== 64'd0 || ib.rdat !== 64'd0) begin
         fails++;
         $display("FAIL r0_read: a=%h b=%h want 0", ia.rdat, ib.rdat);
      end
   endtask

   task automatic test_bypass;
      ia.wen = 2'b01; ia.wsel[4:0] = 5'd7; ia.wdat[31:0] = 32'h11111111;
      ib.wen = 1'b1;  ib.wsel      = 5'd7; ib.wdat      = 32'h11111111;
      next_cycle();
      ia.wdat[31:0] = 32'hA5A5A5A5; ia.rsel[9:5] = 5'd7;
      ib.wdat       = 32'hA5A5A5A5; ib.rsel[9:5] = 5'd7;
      #1;
      tests++;
      if (ia.rdat[63:32] !== 32'hA5A5A5A5) begin
         fails++;
         $display("FAIL bypass_on: got %h want a5a5a5a5", ia.rdat[63:32]);
      end
      tests++;
      if (ib.rdat[63:32] !== 32'h11111111) begin
         fails++;
         $display("FAIL bypass_off: got %h want 11111111", ib.rdat[63:32]);
      end
      next_cycle();
      idle();
      ia.rsel[9:5] = 5'd7; ib.rsel[9:5] = 5'd7;
      #1;
      tests++;
      if (ib.rdat[63:32] !== 32'hA5A5A5A5 || ia.rdat[63:32] !== 32'hA5A5A5A5) begin
         fails++;
         $display("FAIL bypass_after: a=%h b=%h want a5a5a5a5", ia.rdat[63:32], ib.rdat[63:32]);
      end
   endtask

   task automatic test_conflict;
      idle();
      ia.wen = 2'b11; ia.wsel = {5'd3, 5'd3}; ia.wdat = {32'd66, 32'd55}; ia.rsel[4:0] = 5'd3;
      #1;
      tests++;
      if (ia.rdat[31:0] !== 32'd66) begin
         fails++;
         $display("FAIL conflict_bypass: got %0d want 66", ia.rdat[31:0]);
      end
      next_cycle();
      idle();
      ia.rsel[4:0] = 5'd3;
      #1;
      tests++;
      if (ia.rdat[31:0] !== 32'd66) begin
         fails++;
         $display("FAIL conflict_r3: got %0d want 66", ia.rdat[31:0]);
      end
   endtask

   task automatic test_scoreboard;
      idle();
      ia.claim_en = 1'b1; ia.claim_sel = 5'd9;
      ib.claim_en = 1'b1; ib.claim_sel = 5'd9;
      next_cycle();
      idle();
      ia.rsel[4:0] = 5'd9; ib.rsel[4:0] = 5'd9;
      #1;
      tests++;
      if (ia.busy_vec !== 32'h200 || ib.busy_vec !== 32'h200 || ia.rbusy[0] !== 1'b1) begin
         fails++;
         $display("FAIL claim_r9: a=%h b=%h rbusy=%b want 200/200/1", ia.busy_vec, ib.busy_vec, ia.rbusy[0]);
      end
      ia.wen = 2'b01; ia.wsel[4:0] = 5'd9; ia.wdat[31:0] = 32'd77;
      ib.wen = 1'b1;  ib.wsel      = 5'd9; ib.wdat      = 32'd77;
      #1;
      tests++;
      if (ia.rbusy[0] !== 1'b0 || ib.rbusy[0] !== 1'b1) begin
         fails++;
         $display("FAIL wb_rbusy: a=%b b=%b want 0/1", ia.rbusy[0], ib.rbusy[0]);
      end
      next_cycle();
      idle();
      #1;
      tests++;
      if (ia.busy_vec !== 32'd0 || ib.busy_vec !== 32'd0) begin
         fails++;
         $display("FAIL wb_clear: a=%h b=%h want 0", ia.busy_vec, ib.busy_vec);
      end
      ia.claim_en = 1'b1; ia.claim_sel = 5'd9;
      next_cycle();
      ia.wen = 2'b01; ia.wsel[4:0] = 5'd9; ia.wdat[31:0] = 32'd88; ia.rsel[4:0] = 5'd9;
      #1;
      tests++;
      if (ia.rbusy[0] !== 1'b1) begin
         fails++;
         $display("FAIL claim_wb_rbusy: got %b want 1", ia.rbusy[0]);
      end
      next_cycle();
      idle();
      #1;
      tests++;
      if (ia.busy_vec !== 32'h200) begin
         fails++;
         $display("FAIL claim_wins: got %h want 200", ia.busy_vec);
      end
      ia.claim_en = 1'b1; ia.claim_sel = 5'd0;
      next_cycle();
      idle();
      #1;
      tests++;
      if (ia.busy_vec !== 32'h200 || ia.rbusy[0] !== 1'b0) begin
         fails++;
         $display("FAIL claim_r0: busy=%h rbusy=%b want 200/0", ia.busy_vec, ia.rbusy[0]);
      end
   endtask

   task automatic test_reset_midop;
      idle();
      mdl[0] = 32'd0;
      for (int r = 1; r < 32; r++) begin
         mdl[r] = $urandom();
         ia.wen = 2'b01; ia.wsel[4:0] = 5'(r); ia.wdat[31:0] = mdl[r];
         next_cycle();
      end
      idle();
      for (int r = 0; r < 32; r++) begin
         ia.rsel[4:0] = 5'(r);
         #1;
         tests++;
         if (ia.rdat[31:0] !== mdl[r]) begin
            fails++;
            $display("FAIL fill r%0d: got %h want %h", r, ia.rdat[31:0], mdl[r]);
         end
      end
      ia.claim_en = 1'b1; ia.claim_sel = 5'd4;
      next_cycle();
      ia.claim_sel = 5'd6; ia.rsel = {5'd6, 5'd4};
      #2;
      n_rst = 1'b0;
      #1;
      tests++;
      if (ia.busy_vec !== 32'd0 || ia.rdat !== 64'd0 || ia.rbusy !== 2'b00) begin
         fails++;
         $display("FAIL midop_reset: busy=%h rdat=%h rbusy=%b want 0", ia.busy_vec, ia.rdat, ia.rbusy);
      end
      next_cycle();
      ia.claim_en = 1'b0;
      n_rst = 1'b1;
      next_cycle();
      tests++;
      if (ia.busy_vec !== 32'd0 || ia.rdat !== 64'd0) begin
         fails++;
         $display("FAIL after_reset: busy=%h rdat=%h want 0", ia.busy_vec, ia.rdat);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      n_rst = 1'b0;
      idle();
      test_reset();
      test_write_read();
      test_bypass();
      test_conflict();
      test_scoreboard();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
